trap_entry_sequencer: RTL and testbench
=======================================

Name: trap_entry_sequencer

Overview:
- Consumes one committed exception from the commit stage and applies the delegation decision from the exception privilege router (medeleg lookup).
- Produces the trap-entry CSR write bundle, the pipeline flush and the front-end redirect to the trap vector.
- Sits between commit/ROB retirement and the CSR file / fetch redirect path.
- Handles one trap at a time under a 4-state FSM.

Parameters:
- XLEN, 32, width of PC, tval, cause and tvec values.

Ports:
- cpu_clock_i  input  1  core clock
- cpu_reset_i  input  1  synchronous active-high reset
- exc_valid_i  input  1  commit presents an exception
- exc_ready_o  output  1  sequencer accepts the exception (handshake completes when valid&ready)
- exc_code_i  input  4  exception code, 0..15
- exc_pc_i  input  XLEN  PC of the faulting instruction
- exc_tval_i  input  XLEN  trap value
- current_privilege_i  input  2  current mode (00 U, 01 S, 11 M)
- router_code_o  output  4  latched code, driven to the router
- router_privilege_i  input  2  router result (01 or 11), combinational from router_code_o
- mtvec_i  input  XLEN  machine trap vector CSR
- stvec_i  input  XLEN  supervisor trap vector CSR
- trap_we_o  output  1  one-cycle CSR trap-entry write strobe
- trap_target_o  output  2  privilege being entered
- trap_prev_priv_o  output  2  privilege at trap time (for MPP/SPP)
- trap_epc_o  output  XLEN  value for mepc/sepc
- trap_cause_o  output  XLEN  value for mcause/scause
- trap_tval_o  output  XLEN  value for mtval/stval
- flush_o  output  1  one-cycle pipeline flush pulse
- redirect_valid_o  output  1  redirect request to fetch
- redirect_pc_o  output  XLEN  trap handler address
- redirect_ready_i  input  1  fetch accepts redirect

Behaviour:
- Reset (synchronous, while cpu_reset_i=1 at a clock edge):
  - FSM goes to IDLE.
  - All outputs 0, except exc_ready_o=1 once out of reset in IDLE.
  - All latched registers are cleared.
  - Reset overrides any in-flight trap; no CSR write or redirect is issued for that trap.
- IDLE:
  - exc_ready_o=1.
  - On exc_valid_i&exc_ready_o, latch code, pc, tval and current_privilege_i, then go to ROUTE.
  - exc_ready_o is 0 in every other state; commit holds its request.
- ROUTE (1 cycle):
  - router_code_o = latched code.
  - Register router_privilege_i as target.
  - Register the vector base: mtvec_i if target=11, else stvec_i, with bits[1:0] forced to 0. Exceptions are always direct mode, regardless of tvec mode bits.
  - Go to WRITE.
- WRITE (1 cycle):
  - trap_we_o=1 and flush_o=1 for exactly this cycle.
  - trap_target_o = target; trap_prev_priv_o = latched privilege.
  - trap_epc_o = latched pc with bit0 cleared.
  - trap_cause_o = zero-extended code (bit XLEN-1 = 0).
  - trap_tval_o = latched tval.
  - Go to REDIRECT.
- REDIRECT:
  - redirect_valid_o=1; redirect_pc_o = vector base.
  - Hold both stable until redirect_ready_i=1.
  - On the accept cycle, return to IDLE; redirect_valid_o=0 on the next cycle.
  - If redirect_ready_i is already 1 on entry, REDIRECT lasts one cycle.
- Latency: minimum 4 cycles from handshake to exc_ready_o reasserting (accept, ROUTE, WRITE, REDIRECT).
- Data outputs (trap_* buses, redirect_pc_o) hold their last values between strobes and are only meaningful while the associated strobe is high.
- router_code_o holds the latched code until the next accepted exception.
- Inputs sampled only as above; changes to mtvec_i, stvec_i or current_privilege_i after sampling are ignored for the in-flight trap.
- A back-to-back exc_valid_i during a trap is stalled, never dropped or merged.

Test Plan:
- Reset mid-REDIRECT with redirect_ready_i=0 → next cycle redirect_valid_o=0, FSM in IDLE, exc_ready_o=1; no further trap_we_o pulse.
- Code 2, priv 00, router returns 11, mtvec=0x8000_0101 → after 2 cycles trap_we_o pulse with cause 0x2, target 11, prev 00, epc=pc; next cycle redirect_pc_o=0x8000_0100.
- Code 8 (ecall-U), priv 00, router returns 01, stvec=0x0000_4003, pc=0x1235 → target 01, epc=0x1234, redirect_pc_o=0x0000_4000, flush_o high exactly 1 cycle.
- Code 15, tval=0xDEAD_BEEF → trap_cause_o=0x0000_000F, bit31=0, trap_tval_o=0xDEAD_BEEF.
- redirect_ready_i held 0 for 5 cycles → redirect_valid_o and redirect_pc_o stable for 6 cycles, exc_ready_o=0 throughout, a second exc_valid_i stays pending and is accepted only after return to IDLE.
- Two exceptions back-to-back with redirect_ready_i=1 → second handshake exactly 4 cycles after the first, with two distinct trap_we_o pulses.

Source files
------------

// File: rtl/trap_entry_sequencer_if.sv
// Trap-entry sequencer bus: commit-side exception handshake, router lookup,
// CSR trap-entry write bundle, pipeline flush and front-end redirect.
interface trap_entry_sequencer_if #(
    parameter int XLEN = 32
);
    logic            exc_valid_i;
    logic            exc_ready_o;
    logic [3:0]      exc_code_i;
    logic [XLEN-1:0] exc_pc_i;
    logic [XLEN-1:0] exc_tval_i;
    logic [1:0]      current_privilege_i;
    logic [3:0]      router_code_o;
    logic [1:0]      router_privilege_i;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] stvec_i;
    logic            trap_we_o;
    logic [1:0]      trap_target_o;
    logic [1:0]      trap_prev_priv_o;
    logic [XLEN-1:0] trap_epc_o;
    logic [XLEN-1:0] trap_cause_o;
    logic [XLEN-1:0] trap_tval_o;
    logic            flush_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            redirect_ready_i;

    // Sequencer side
    modport slave (
        input  exc_valid_i, exc_code_i, exc_pc_i, exc_tval_i, current_privilege_i,
        input  router_privilege_i, mtvec_i, stvec_i, redirect_ready_i,
        output exc_ready_o, router_code_o, trap_we_o, trap_target_o, trap_prev_priv_o,
        output trap_epc_o, trap_cause_o, trap_tval_o, flush_o, redirect_valid_o,
        output redirect_pc_o
    );

    // Surrounding core side (commit, router, CSR file, fetch)
    modport master (
        output exc_valid_i, exc_code_i, exc_pc_i, exc_tval_i, current_privilege_i,
        output router_privilege_i, mtvec_i, stvec_i, redirect_ready_i,
        input  exc_ready_o, router_code_o, trap_we_o, trap_target_o, trap_prev_priv_o,
        input  trap_epc_o, trap_cause_o, trap_tval_o, flush_o, redirect_valid_o,
        input  redirect_pc_o
    );
endinterface

// File: rtl/trap_entry_sequencer.sv
// Trap-entry sequencer: takes one committed exception at a time, resolves the
// delegated target privilege through the router, issues the CSR trap-entry
// write together with a pipeline flush, then redirects fetch to the handler.
module trap_entry_sequencer #(
    parameter int XLEN = 32
) (
    input  logic                   cpu_clock_i,
    input  logic                   cpu_reset_i,
    trap_entry_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROUTE    = 2'd1,
        ST_WRITE    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    // Exceptions always enter in direct mode, so the tvec mode bits are dropped.
    function automatic logic [XLEN-1:0] direct_base(input logic [XLEN-1:0] tvec);
        return {tvec[XLEN-1:2], 2'b00};
    endfunction

    state_t          state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] tval_r;
    logic [1:0]      priv_r;
    logic [XLEN-1:0] vbase_r;

    logic            exc_ready_r;
    logic [3:0]      router_code_r;
    logic            trap_we_r;
    logic [1:0]      trap_target_r;
    logic [1:0]      trap_prev_priv_r;
    logic [XLEN-1:0] trap_epc_r;
    logic [XLEN-1:0] trap_cause_r;
    logic [XLEN-1:0] trap_tval_r;
    logic            flush_r;
    logic            redirect_valid_r;
    logic [XLEN-1:0] redirect_pc_r;

    // Trap sequencing FSM with all outputs registered.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            state_r          <= ST_IDLE;
            pc_r             <= {XLEN{1'b0}};
            tval_r           <= {XLEN{1'b0}};
            priv_r           <= 2'b00;
            vbase_r          <= {XLEN{1'b0}};
            exc_ready_r      <= 1'b1;
            router_code_r    <= 4'd0;
            trap_we_r        <= 1'b0;
            trap_target_r    <= 2'b00;
            trap_prev_priv_r <= 2'b00;
            trap_epc_r       <= {XLEN{1'b0}};
            trap_cause_r     <= {XLEN{1'b0}};
            trap_tval_r      <= {XLEN{1'b0}};
            flush_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {XLEN{1'b0}};
        end else begin
            // CSR write and flush are single-cycle pulses unless re-armed below.
            trap_we_r <= 1'b0;
            flush_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.exc_valid_i && exc_ready_r) begin
                        router_code_r <= bus.exc_code_i;
                        pc_r          <= bus.exc_pc_i;
                        tval_r        <= bus.exc_tval_i;
                        priv_r        <= bus.current_privilege_i;
                        exc_ready_r   <= 1'b0;
                        state_r       <= ST_ROUTE;
                    end else begin
                        exc_ready_r   <= 1'b1;
                    end
                end
                ST_ROUTE: begin
                    // Router answers combinationally from router_code_o.
                    trap_target_r    <= bus.router_privilege_i;
                    vbase_r          <= (bus.router_privilege_i == 2'b11) ?
                                        direct_base(bus.mtvec_i) : direct_base(bus.stvec_i);
                    trap_we_r        <= 1'b1;
                    flush_r          <= 1'b1;
                    trap_prev_priv_r <= priv_r;
                    trap_epc_r       <= {pc_r[XLEN-1:1], 1'b0};
                    trap_cause_r     <= {{(XLEN-4){1'b0}}, router_code_r};
                    trap_tval_r      <= tval_r;
                    state_r          <= ST_WRITE;
                end
                ST_WRITE: begin
                    redirect_valid_r <= 1'b1;
                    redirect_pc_r    <= vbase_r;
                    state_r          <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (bus.redirect_ready_i) begin
                        redirect_valid_r <= 1'b0;
                        exc_ready_r      <= 1'b1;
                        state_r          <= ST_IDLE;
                    end else begin
                        redirect_valid_r <= 1'b1;
                    end
                end
                default: begin
                    redirect_valid_r <= 1'b0;
                    exc_ready_r      <= 1'b1;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.exc_ready_o      = exc_ready_r;
    assign bus.router_code_o    = router_code_r;
    assign bus.trap_we_o        = trap_we_r;
    assign bus.trap_target_o    = trap_target_r;
    assign bus.trap_prev_priv_o = trap_prev_priv_r;
    assign bus.trap_epc_o       = trap_epc_r;
    assign bus.trap_cause_o     = trap_cause_r;
    assign bus.trap_tval_o      = trap_tval_r;
    assign bus.flush_o          = flush_r;
    assign bus.redirect_valid_o = redirect_valid_r;
    assign bus.redirect_pc_o    = redirect_pc_r;

endmodule

// File: tb/tb_trap_entry_sequencer.sv
// Directed bench for trap_entry_sequencer: hand-computed expectations,
// inputs driven and outputs sampled on the falling clock edge.
module tb_trap_entry_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] deleg_mask;
    int          errors;
    int          checks;
    int          pulses;

    trap_entry_sequencer_if #(.XLEN(32)) bus ();

    trap_entry_sequencer #(.XLEN(32)) dut (
        .cpu_clock_i (clk),
        .cpu_reset_i (rst),
        .bus         (bus)
    );

    // Router stand-in: delegated codes go to S, everything else to M.
    assign bus.router_privilege_i = deleg_mask[bus.router_code_o] ? 2'b01 : 2'b11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [3:0] code, input logic [31:0] pc,
                           input logic [31:0] tval, input logic [1:0] priv);
        bus.exc_valid_i         = 1'b1;
        bus.exc_code_i          = code;
        bus.exc_pc_i            = pc;
        bus.exc_tval_i          = tval;
        bus.current_privilege_i = priv;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        pulses = 0;
        deleg_mask = 16'h0100;          // only code 8 (ecall-U) delegated to S
        rst = 1'b1;
        bus.exc_valid_i = 1'b0;
        bus.exc_code_i = 4'd0;
        bus.exc_pc_i = 32'd0;
        bus.exc_tval_i = 32'd0;
        bus.current_privilege_i = 2'b00;
        bus.mtvec_i = 32'h8000_0101;
        bus.stvec_i = 32'h0000_4003;
        bus.redirect_ready_i = 1'b1;
        step();
        step();
        chk("rst_ready", bus.exc_ready_o, 32'd1);
        chk("rst_we", bus.trap_we_o, 32'd0);
        chk("rst_rv", bus.redirect_valid_o, 32'd0);
        chk("rst_code", bus.router_code_o, 32'd0);
        rst = 1'b0;
        step();

        // Code 2 from U, router picks M, mtvec mode bits dropped
        present(4'd2, 32'h0000_1000, 32'h0000_0011, 2'b00);
        chk("a_ready_idle", bus.exc_ready_o, 32'd1);
        step();
        bus.exc_valid_i = 1'b0;
        chk("a_route_ready", bus.exc_ready_o, 32'd0);
        chk("a_route_code", bus.router_code_o, 32'd2);
        chk("a_route_we", bus.trap_we_o, 32'd0);
        step();
        bus.mtvec_i = 32'hFFFF_FFFF;    // change after sampling must be ignored
        chk("a_we", bus.trap_we_o, 32'd1);
        chk("a_flush", bus.flush_o, 32'd1);
        chk("a_cause", bus.trap_cause_o, 32'h0000_0002);
        chk("a_target", bus.trap_target_o, 32'd3);
        chk("a_prev", bus.trap_prev_priv_o, 32'd0);
        chk("a_epc", bus.trap_epc_o, 32'h0000_1000);
        chk("a_tval", bus.trap_tval_o, 32'h0000_0011);
        step();
        chk("a_we_off", bus.trap_we_o, 32'd0);
        chk("a_rv", bus.redirect_valid_o, 32'd1);
        chk("a_rpc", bus.redirect_pc_o, 32'h8000_0100);
        step();
        chk("a_rv_off", bus.redirect_valid_o, 32'd0);
        chk("a_ready_back", bus.exc_ready_o, 32'd1);
        bus.mtvec_i = 32'h8000_0101;

        // Code 8 delegated to S, odd pc gets bit0 cleared
        present(4'd8, 32'h0000_1235, 32'h0000_0000, 2'b00);
        step();
        bus.exc_valid_i = 1'b0;
        step();
        chk("b_we", bus.trap_we_o, 32'd1);
        chk("b_flush", bus.flush_o, 32'd1);
        chk("b_target", bus.trap_target_o, 32'd1);
        chk("b_epc", bus.trap_epc_o, 32'h0000_1234);
        chk("b_cause", bus.trap_cause_o, 32'h0000_0008);
        step();
        chk("b_flush_once", bus.flush_o, 32'd0);
        chk("b_rpc", bus.redirect_pc_o, 32'h0000_4000);
        step();
        chk("b_idle", bus.exc_ready_o, 32'd1);

        // Code 15 from S, zero-extended cause, full tval
        present(4'd15, 32'h0000_2000, 32'hDEAD_BEEF, 2'b01);
        step();
        bus.exc_valid_i = 1'b0;
        step();
        chk("c_cause", bus.trap_cause_o, 32'h0000_000F);
        chk("c_cause_msb", {31'd0, bus.trap_cause_o[31]}, 32'd0);
        chk("c_tval", bus.trap_tval_o, 32'hDEAD_BEEF);
        chk("c_prev", bus.trap_prev_priv_o, 32'd1);
        chk("c_target", bus.trap_target_o, 32'd3);
        step();
        step();

        // Redirect back-pressure with a second exception pending behind it
        bus.redirect_ready_i = 1'b0;
        present(4'd5, 32'h0000_2000, 32'h0000_0055, 2'b11);
        step();
        present(4'd7, 32'h0000_3000, 32'h0000_0077, 2'b00);
        step();
        step();
        chk("d_rv_0", bus.redirect_valid_o, 32'd1);
        chk("d_rpc_0", bus.redirect_pc_o, 32'h8000_0100);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("d_rv_hold", bus.redirect_valid_o, 32'd1);
            chk("d_rpc_hold", bus.redirect_pc_o, 32'h8000_0100);
            chk("d_ready_low", bus.exc_ready_o, 32'd0);
            chk("d_code_hold", bus.router_code_o, 32'd5);
        end
        bus.redirect_ready_i = 1'b1;
        step();
        chk("d_rv_off", bus.redirect_valid_o, 32'd0);
        chk("d_ready_back", bus.exc_ready_o, 32'd1);
        chk("d_not_yet", bus.router_code_o, 32'd5);
        step();
        bus.exc_valid_i = 1'b0;
        chk("d_second_code", bus.router_code_o, 32'd7);
        chk("d_second_ready", bus.exc_ready_o, 32'd0);
        step();
        chk("d_second_we", bus.trap_we_o, 32'd1);
        chk("d_second_epc", bus.trap_epc_o, 32'h0000_3000);
        chk("d_second_cause", bus.trap_cause_o, 32'h0000_0007);
        step();
        step();

        // Back-to-back: second handshake four cycles after the first
        present(4'd1, 32'h0000_0100, 32'h0000_0001, 2'b00);
        step();
        present(4'd3, 32'h0000_0200, 32'h0000_0003, 2'b00);
        chk("e_code1", bus.router_code_o, 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (bus.trap_we_o === 1'b1) pulses++;
            chk("e_ready_busy", bus.exc_ready_o, 32'd0);
            step();
        end
        chk("e_ready_cycle4", bus.exc_ready_o, 32'd1);
        step();
        bus.exc_valid_i = 1'b0;
        chk("e_code2", bus.router_code_o, 32'd3);
        step();
        if (bus.trap_we_o === 1'b1) pulses++;
        chk("e_epc2", bus.trap_epc_o, 32'h0000_0200);
        chk("e_pulses", pulses, 32'd2);
        step();
        step();

        // Reset while REDIRECT is stalled aborts the trap cleanly
        bus.redirect_ready_i = 1'b0;
        present(4'd4, 32'h0000_4444, 32'h0000_0004, 2'b00);
        step();
        bus.exc_valid_i = 1'b0;
        step();
        step();
        chk("f_rv_pre", bus.redirect_valid_o, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("f_rv_reset", bus.redirect_valid_o, 32'd0);
        chk("f_ready_reset", bus.exc_ready_o, 32'd1);
        chk("f_code_reset", bus.router_code_o, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("f_no_we", bus.trap_we_o, 32'd0);
            chk("f_no_rv", bus.redirect_valid_o, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
